// File: rtl/nanocache_mem_arbiter.sv
// Round-robin line arbiter between the nano cache instruction and data miss engines.
// Drives a single-port SRAM with a fixed read latency and returns registered read lines.
module nanocache_mem_arbiter #(
  parameter int LINE_AW    = 10,
  parameter int RD_LATENCY = 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_mm_rden_instr,
  input  logic [31:0]          i_mm_addr_instr,
  output logic                 o_mm_gnt_instr,
  output logic                 o_mm_rvalid_instr,
  output logic [7:0][31:0]     o_mm_rdata_instr,
  input  logic                 i_mm_rden_data,
  input  logic                 i_mm_wren_data,
  input  logic [31:0]          i_mm_addr_data,
  input  logic [7:0][31:0]     i_mm_wdata_data,
  output logic                 o_mm_gnt_data,
  output logic                 o_mm_rvalid_data,
  output logic [7:0][31:0]     o_mm_rdata_data,
  output logic                 o_sram_en,
  output logic                 o_sram_we,
  output logic [LINE_AW-1:0]   o_sram_addr,
  output logic [7:0][31:0]     o_sram_wdata,
  input  logic [7:0][31:0]     i_sram_rdata,
  output logic [1:0]           o_dbg_state
);

  // Request/grant: a requester holds rden/wren (and addr/wdata) until it sees its gnt
  // high in the same cycle; the request is consumed on that clock edge. rvalid is a
  // one-cycle pulse with no back-pressure.
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t     state;
  logic       ptr_data;   // last granted side: 1 = data, 0 = instr
  logic       side_data;  // side owning the in-flight read
  logic [2:0] cnt;

  logic pend_instr, pend_data, can_grant, pick_data;
  logic unused_addr_bits;

  assign unused_addr_bits = ^{i_mm_addr_instr[31:LINE_AW+5], i_mm_addr_instr[4:0],
                              i_mm_addr_data[31:LINE_AW+5], i_mm_addr_data[4:0]};
  assign o_dbg_state = state;

  // RESP doubles as an idle cycle so a new grant overlaps the response pulse.
  always_comb begin
    pend_instr     = i_mm_rden_instr;
    pend_data      = i_mm_rden_data | i_mm_wren_data;
    can_grant      = ((state == IDLE) || (state == RESP)) && !i_rst;
    pick_data      = pend_data && (!pend_instr || !ptr_data);
    o_mm_gnt_data  = can_grant && pick_data;
    o_mm_gnt_instr = can_grant && pend_instr && !pick_data;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state             <= IDLE;
      ptr_data          <= 1'b0;
      side_data         <= 1'b0;
      cnt               <= '0;
      o_sram_en         <= 1'b0;
      o_sram_we         <= 1'b0;
      o_sram_addr       <= '0;
      o_sram_wdata      <= '0;
      o_mm_rvalid_instr <= 1'b0;
      o_mm_rvalid_data  <= 1'b0;
      o_mm_rdata_instr  <= '0;
      o_mm_rdata_data   <= '0;
    end else begin
      o_sram_en         <= 1'b0;
      o_mm_rvalid_instr <= 1'b0;
      o_mm_rvalid_data  <= 1'b0;
      case (state)
        IDLE, RESP: begin
          if (o_mm_gnt_instr || o_mm_gnt_data) begin
            state     <= ISSUE;
            ptr_data  <= o_mm_gnt_data;
            side_data <= o_mm_gnt_data;
            o_sram_en <= 1'b1;
            // A data request with both rden and wren is a pure write-back.
            o_sram_we <= o_mm_gnt_data && i_mm_wren_data;
            if (o_mm_gnt_data) begin
              o_sram_addr <= i_mm_addr_data[LINE_AW+4:5];
              if (i_mm_wren_data) o_sram_wdata <= i_mm_wdata_data;
            end else begin
              o_sram_addr <= i_mm_addr_instr[LINE_AW+4:5];
            end
          end else begin
            state <= IDLE;
          end
        end
        ISSUE: begin
          if (o_sram_we) begin
            state <= IDLE;
          end else begin
            state <= WAIT;
            cnt   <= 3'(RD_LATENCY);
          end
        end
        WAIT: begin
          cnt <= cnt - 3'd1;
          if (cnt == 3'd1) begin
            state <= RESP;
            if (side_data) begin
              o_mm_rdata_data  <= i_sram_rdata;
              o_mm_rvalid_data <= 1'b1;
            end else begin
              o_mm_rdata_instr  <= i_sram_rdata;
              o_mm_rvalid_instr <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nanocache_mem_arbiter.sv
// Directed bench for nanocache_mem_arbiter: table of single transactions plus
// hand-written sequences for contention, reset mid-read and a 4-cycle SRAM latency.
module tb_nanocache_mem_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // DUT a: default latency
  logic             rden_instr = 0, rden_data = 0, wren_data = 0;
  logic [31:0]      addr_instr = 0, addr_data = 0;
  logic [7:0][31:0] wdata_data = '0;
  logic             gnt_instr, gnt_data, rvalid_instr, rvalid_data;
  logic [7:0][31:0] rdata_instr, rdata_data;
  logic             sram_en, sram_we;
  logic [9:0]       sram_addr;
  logic [7:0][31:0] sram_wdata, sram_rdata;
  logic [1:0]       dbg_state;

  // DUT b: RD_LATENCY = 4, instruction side only
  logic             b_rden_instr = 0;
  logic [31:0]      b_addr_instr = 0;
  logic             b_gnt_instr, b_gnt_data, b_rvalid_instr, b_rvalid_data;
  logic [7:0][31:0] b_rdata_instr, b_rdata_data;
  logic             b_sram_en, b_sram_we;
  logic [9:0]       b_sram_addr;
  logic [7:0][31:0] unused_b_wdata, b_sram_rdata;
  logic [1:0]       unused_b_state;

  nanocache_mem_arbiter u_dut (
    .i_clk(clk), .i_rst(rst),
    .i_mm_rden_instr(rden_instr), .i_mm_addr_instr(addr_instr),
    .o_mm_gnt_instr(gnt_instr), .o_mm_rvalid_instr(rvalid_instr), .o_mm_rdata_instr(rdata_instr),
    .i_mm_rden_data(rden_data), .i_mm_wren_data(wren_data), .i_mm_addr_data(addr_data),
    .i_mm_wdata_data(wdata_data),
    .o_mm_gnt_data(gnt_data), .o_mm_rvalid_data(rvalid_data), .o_mm_rdata_data(rdata_data),
    .o_sram_en(sram_en), .o_sram_we(sram_we), .o_sram_addr(sram_addr),
    .o_sram_wdata(sram_wdata), .i_sram_rdata(sram_rdata), .o_dbg_state(dbg_state)
  );

  nanocache_mem_arbiter #(.LINE_AW(10), .RD_LATENCY(4)) u_dut4 (
    .i_clk(clk), .i_rst(rst),
    .i_mm_rden_instr(b_rden_instr), .i_mm_addr_instr(b_addr_instr),
    .o_mm_gnt_instr(b_gnt_instr), .o_mm_rvalid_instr(b_rvalid_instr), .o_mm_rdata_instr(b_rdata_instr),
    .i_mm_rden_data(1'b0), .i_mm_wren_data(1'b0), .i_mm_addr_data(32'h0),
    .i_mm_wdata_data(256'h0),
    .o_mm_gnt_data(b_gnt_data), .o_mm_rvalid_data(b_rvalid_data), .o_mm_rdata_data(b_rdata_data),
    .o_sram_en(b_sram_en), .o_sram_we(b_sram_we), .o_sram_addr(b_sram_addr),
    .o_sram_wdata(unused_b_wdata), .i_sram_rdata(b_sram_rdata), .o_dbg_state(unused_b_state)
  );

  function automatic logic [255:0] make_line(input logic [31:0] base);
    logic [7:0][31:0] l;
    for (int i = 0; i < 8; i++) l[i] = base + 32'(i);
    return l;
  endfunction

  function automatic logic [255:0] rand_line();
    logic [7:0][31:0] l;
    for (int i = 0; i < 8; i++) l[i] = $urandom;
    return l;
  endfunction

  // SRAM models: line n initially holds words 0x1000_0000 | n<<8, +0..+7;
  // outside a valid read slot the read bus carries random garbage.
  logic [255:0] mem_a [0:1023];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 1024; i++) mem_a[i] <= make_line(32'h1000_0000 | (32'(i) << 8));
    end else if (sram_en && sram_we) begin
      mem_a[sram_addr] <= sram_wdata;
    end
    if (sram_en && !sram_we) sram_rdata <= mem_a[sram_addr];
    else                     sram_rdata <= rand_line();
  end

  logic [255:0] b_pipe [0:3];
  always @(posedge clk) begin
    if (b_sram_en && !b_sram_we) b_pipe[0] <= make_line(32'h1000_0000 | (32'(b_sram_addr) << 8));
    else                         b_pipe[0] <= rand_line();
    for (int i = 1; i < 4; i++) b_pipe[i] <= b_pipe[i-1];
  end
  assign b_sram_rdata = b_pipe[3];

  // Scoreboard
  int n_checks = 0;
  int n_fail   = 0;
  logic [255:0] exp_q[$];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_gnt(input bit on_b);
    int n = 0;
    while (!(on_b ? (b_gnt_instr || b_gnt_data) : (gnt_instr || gnt_data)) && n < 20) begin
      step();
      n++;
    end
  endtask

  typedef struct {
    logic         is_data;
    logic         rd;
    logic         wr;
    logic [31:0]  addr;
    logic [31:0]  wbase;
    logic [9:0]   exp_line;
    logic [255:0] exp_rdata;
  } vec_t;

  // Drive one request, wait for its grant, then follow it through the SRAM slot.
  task automatic run_vec(input vec_t v, input string name);
    logic [1:0]   exp_rv;
    logic [255:0] e;
    int           rv_seen;
    exp_rv = v.is_data ? 2'b01 : 2'b10;
    if (v.is_data) begin
      rden_data  = v.rd;
      wren_data  = v.wr;
      addr_data  = v.addr;
      wdata_data = make_line(v.wbase);
    end else begin
      rden_instr = 1'b1;
      addr_instr = v.addr;
    end
    #1;
    wait_gnt(1'b0);
    chk({name, "_gnt"}, {gnt_instr, gnt_data}, exp_rv);
    if (!v.wr) exp_q.push_back(v.exp_rdata);
    step();
    rden_instr = 0; rden_data = 0; wren_data = 0;
    chk({name, "_en"}, sram_en, 1'b1);
    chk({name, "_we"}, sram_we, v.wr);
    chk({name, "_addr"}, sram_addr, v.exp_line);
    if (v.wr) chk({name, "_wdata"}, sram_wdata, make_line(v.wbase));
    step();
    chk({name, "_en_drop"}, {sram_en, gnt_instr, gnt_data}, 3'b000);
    if (v.wr) begin
      rv_seen = 0;
      for (int k = 0; k < 4; k++) begin
        if (rvalid_instr || rvalid_data) rv_seen++;
        step();
      end
      chk({name, "_no_rvalid"}, rv_seen, 0);
    end else begin
      chk({name, "_rv_early"}, {rvalid_instr, rvalid_data}, 2'b00);
      step();
      chk({name, "_rvalid"}, {rvalid_instr, rvalid_data}, exp_rv);
      e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
      chk({name, "_rdata"}, v.is_data ? rdata_data : rdata_instr, e);
      step();
      chk({name, "_rv_pulse"}, {rvalid_instr, rvalid_data}, 2'b00);
    end
  endtask

  vec_t vecs[10];

  initial begin
    logic ei, ed, eri, erd;

    vecs[0] = '{1'b0, 1'b1, 1'b0, 32'h0000_0040, 32'h0,     10'd2,     make_line(32'h1000_0200)};
    vecs[1] = '{1'b1, 1'b0, 1'b1, 32'h0000_0060, 32'h1,     10'd3,     '0};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 32'h0000_0060, 32'h0,     10'd3,     make_line(32'h1)};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 32'h0000_7FE0, 32'h0,     10'h3FF,   make_line(32'h1003_FF00)};
    vecs[4] = '{1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'h100,   10'h3FF,   '0};
    vecs[5] = '{1'b0, 1'b1, 1'b0, 32'h0000_801F, 32'h0,     10'd0,     make_line(32'h1000_0000)};
    vecs[6] = '{1'b1, 1'b1, 1'b0, 32'h0000_7FFF, 32'h0,     10'h3FF,   make_line(32'h100)};
    vecs[7] = '{1'b1, 1'b1, 1'b1, 32'h0000_00C0, 32'h55,    10'd6,     '0};
    vecs[8] = '{1'b0, 1'b1, 1'b0, 32'h0000_00C0, 32'h0,     10'd6,     make_line(32'h55)};
    vecs[9] = '{1'b1, 1'b1, 1'b0, 32'h0000_0040, 32'h0,     10'd2,     make_line(32'h1000_0200)};

    // Reset values
    repeat (3) step();
    chk("rst_sram", {sram_en, sram_we, sram_addr}, '0);
    chk("rst_wdata", sram_wdata, '0);
    chk("rst_hs", {gnt_instr, gnt_data, rvalid_instr, rvalid_data}, 4'b0000);
    chk("rst_rdata_i", rdata_instr, '0);
    chk("rst_rdata_d", rdata_data, '0);
    chk("rst_state", dbg_state, 2'd0);

    // Both sides read continuously from reset: data wins first, then alternate.
    rden_instr = 1; addr_instr = 32'h0000_00A0;
    rden_data  = 1; addr_data  = 32'h0000_0080;
    #1;
    chk("rst_gnt_gated", {gnt_instr, gnt_data}, 2'b00);
    rst = 0;
    #1;
    for (int c = 0; c <= 12; c++) begin
      ed  = (c % 6 == 0);
      ei  = (c % 6 == 3);
      erd = (c > 0) && (c % 6 == 3);
      eri = (c > 0) && (c % 6 == 0);
      chk($sformatf("rr_gnt_c%0d", c), {gnt_instr, gnt_data}, {ei, ed});
      chk($sformatf("rr_rvalid_c%0d", c), {rvalid_instr, rvalid_data}, {eri, erd});
      if (erd) chk($sformatf("rr_rdata_d_c%0d", c), rdata_data, make_line(32'h1000_0400));
      if (eri) chk($sformatf("rr_rdata_i_c%0d", c), rdata_instr, make_line(32'h1000_0500));
      step();
    end
    rden_instr = 0; rden_data = 0;
    repeat (5) step();

    for (int i = 0; i < 10; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Reset two cycles after a read grant aborts it
    rden_instr = 1; addr_instr = 32'h0000_0040;
    #1;
    wait_gnt(1'b0);
    chk("abort_gnt", {gnt_instr, gnt_data}, 2'b10);
    step();
    rden_instr = 0;
    step();
    rst = 1; rden_instr = 1;
    step();
    chk("abort_hs", {gnt_instr, gnt_data, rvalid_instr, rvalid_data}, 4'b0000);
    chk("abort_sram", {sram_en, sram_we, sram_addr}, '0);
    chk("abort_wdata", sram_wdata, '0);
    chk("abort_rdata_i", rdata_instr, '0);
    chk("abort_rdata_d", rdata_data, '0);
    step();
    chk("abort_rvalid_late", {rvalid_instr, rvalid_data}, 2'b00);
    rst = 0;
    #1;
    chk("abort_regrant", {gnt_instr, gnt_data}, 2'b10);
    run_vec(vecs[0], "after_rst");

    // Four-cycle SRAM latency on the second instance
    b_rden_instr = 1; b_addr_instr = 32'h0000_0040;
    #1;
    wait_gnt(1'b1);
    chk("lat4_gnt", {b_gnt_instr, b_gnt_data}, 2'b10);
    exp_q.push_back(make_line(32'h1000_0200));
    step();
    b_rden_instr = 0;
    chk("lat4_en", {b_sram_en, b_sram_we, b_sram_addr}, {1'b1, 1'b0, 10'd2});
    for (int k = 2; k <= 5; k++) begin
      step();
      chk($sformatf("lat4_quiet_t%0d", k), {b_rvalid_instr, b_rvalid_data}, 2'b00);
    end
    step();
    chk("lat4_rvalid", {b_rvalid_instr, b_rvalid_data}, 2'b10);
    chk("lat4_rdata", b_rdata_instr, (exp_q.size() != 0) ? exp_q.pop_front() : '0);
    step();
    chk("lat4_pulse", b_rvalid_instr, 1'b0);
    chk("lat4_rdata_d", b_rdata_data, '0);

    chk("sb_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog actual=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/nanocache_mem_arbiter.md
# nanocache_mem_arbiter

Line-granular main-memory arbiter sitting directly downstream of the nano cache's two miss/update engines (instruction and data). It accepts 256-bit line read requests from the instruction side and line read or write-back requests from the data side, arbitrates round-robin, and drives a single-port SRAM with a fixed read latency. Read data is registered and returned to the requesting side with a one-cycle valid pulse.

## Interface
Parameters:
- LINE_AW, 10, SRAM line-address width; SRAM holds 2^LINE_AW lines of 8x32b.
- RD_LATENCY, 1, SRAM read latency in cycles, legal 1..4.

Ports (one clock; reset is synchronous and active-high):
- i_clk  in  1  clock
- i_rst  in  1  synchronous active-high reset
- i_mm_rden_instr  in  1  instr line read request, held until granted
- i_mm_addr_instr  in  32  instr byte address; bits [4:0] ignored
- o_mm_gnt_instr  out  1  instr request accepted this cycle
- o_mm_rvalid_instr  out  1  one-cycle pulse, o_mm_rdata_instr valid
- o_mm_rdata_instr  out  [7:0][31:0]  instr line data
- i_mm_rden_data  in  1  data line read request, held until granted
- i_mm_wren_data  in  1  data line write-back request, held until granted
- i_mm_addr_data  in  32  data byte address; bits [4:0] ignored
- i_mm_wdata_data  in  [7:0][31:0]  write-back line
- o_mm_gnt_data  out  1  data request accepted this cycle
- o_mm_rvalid_data  out  1  one-cycle pulse, o_mm_rdata_data valid
- o_mm_rdata_data  out  [7:0][31:0]  data line data
- o_sram_en  out  1  SRAM access strobe
- o_sram_we  out  1  SRAM write enable (qualified by o_sram_en)
- o_sram_addr  out  LINE_AW  line address
- o_sram_wdata  out  [7:0][31:0]  SRAM write line
- i_sram_rdata  in  [7:0][31:0]  SRAM read line, valid RD_LATENCY cycles after en

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: pending set = {instr: rden_instr, data: rden_data | wren_data}. If non-empty, grant one: o_mm_gnt_x combinational, high exactly one cycle, only in IDLE. Same edge latches side, op (write if wren_data), line addr = addr[LINE_AW+4:5], wdata; -> ISSUE.
- Arbitration: round-robin; pointer holds last-granted side; when both pending, grant the other side. Reset pointer = instr (so data wins first contention).
- Data side with rden and wren both high: treated as write only; single gnt consumes both.
- ISSUE: o_sram_en=1 for exactly one cycle (registered outputs), o_sram_we=op, addr/wdata from latch. Write -> IDLE. Read -> WAIT, load counter = RD_LATENCY.
- WAIT: counter decrements each cycle; when it hits 0 capture i_sram_rdata into side's rdata register -> RESP.
- RESP: o_mm_rvalid_<side>=1 for one cycle; rdata register held until next capture for that side. Behaves as IDLE this same cycle (new grant allowed).
- Writes produce no rvalid. Requests never dropped; ungranted requester waits.
- o_sram_we, o_sram_addr, o_sram_wdata: don't-care when o_sram_en=0; implementation holds last values.

## Timing
- Reset: state IDLE, pointer instr, counter 0; o_sram_en, o_sram_we, both gnt, both rvalid = 0; o_sram_addr, o_sram_wdata, both rdata = 0.
- Reset mid-operation aborts transaction; no rvalid issued; pending SRAM read data discarded.
- Read: gnt cycle T, o_sram_en T+1, data sampled T+1+RD_LATENCY, rvalid T+2+RD_LATENCY (T+3 at default). Next grant possible at T+2+RD_LATENCY.
- Write: gnt T, o_sram_en&we T+1, next grant T+2.
- Max one outstanding SRAM access; throughput one read per RD_LATENCY+2 cycles.

## Test plan
- Single instr read, RD_LATENCY=1, addr 0x0000_0040: gnt_instr cycle T, o_sram_addr=2 at T+1, rvalid_instr with SRAM line at T+3, rvalid_data never high.
- Data write-back addr 0x0000_0060, wdata words 0x1..0x8: gnt_data T, en=we=1, addr=3 at T+1; read back via instr port returns words 0x1..0x8.
- Both sides request reads continuously from reset: grant order data, instr, data, instr; each rvalid on correct side only, 3 cycles after its gnt.
- Data rden+wren together: one gnt_data, one write SRAM access, no rvalid_data.
- RD_LATENCY=4: gnt T -> rvalid T+6; i_sram_rdata garbage before T+5 not captured.
- i_rst asserted at T+2 of a read: no rvalid, all outputs 0 next cycle, held request re-granted after reset release.
